// File: rtl/wishbone_master_if_pkg.sv
// Shared constants for the Wishbone master port: FSM encodings and legacy
// pipeline/reset constants.
package wishbone_master_if_pkg;

  localparam logic [1:0] WB_IDLE           = 2'b00;
  localparam logic [1:0] WB_BUSY           = 2'b01;
  localparam logic [1:0] WB_WAIT_FOR_STALL = 2'b11;

  localparam logic        Stop         = 1'b1;
  localparam logic        NoStop       = 1'b0;
  localparam logic        RstEnable    = 1'b0;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

endpackage

// File: rtl/wishbone_master_if_if.sv
// Wishbone B4 classic bus bundle with master/slave views, used to wire the
// master port to a slave or a bench.
interface wishbone_master_if_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned SEL_W = DW / 8
);
  logic [AW-1:0]    adr;
  logic [DW-1:0]    dat_m2s;
  logic [DW-1:0]    dat_s2m;
  logic             we;
  logic [SEL_W-1:0] sel;
  logic             stb;
  logic             cyc;
  logic             ack;
  logic             err;

  modport master (output adr, dat_m2s, we, sel, stb, cyc,
                  input  dat_s2m, ack, err);
  modport slave  (input  adr, dat_m2s, we, sel, stb, cyc,
                  output dat_s2m, ack, err);
endinterface

// File: rtl/wishbone_master_if_timeout_ctr.sv
// BUSY-cycle counter for the forced timeout termination; only built when
// WB_TIMEOUT_EN is defined.
`ifdef WB_TIMEOUT_EN
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter holds (k-1) in the k-th BUSY cycle.
  assign expired = (cnt_q == CW'(TIMEOUT_CYC - 1));
endmodule
`endif

// File: rtl/wishbone_master_if.sv
// Wishbone B4 classic master port: one CPU access -> one bus cycle, with
// stall request, read-data retention, err termination and optional
// timeout (WB_TIMEOUT_EN).
module wishbone_master_if
  import wishbone_master_if_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 32,
  parameter int unsigned SEL_W       = DW / 8,
  parameter int unsigned STALL_W     = 6,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               cpu_ce_i,
  input  logic               cpu_we_i,
  input  logic [AW-1:0]      cpu_addr_i,
  input  logic [DW-1:0]      cpu_data_i,
  input  logic [SEL_W-1:0]   cpu_sel_i,
  output logic [DW-1:0]      cpu_data_o,
  output logic               cpu_err_o,
  output logic               stallreq,
  input  logic [DW-1:0]      wishbone_data_i,
  input  logic               wishbone_ack_i,
  input  logic               wishbone_err_i,
  output logic [AW-1:0]      wishbone_addr_o,
  output logic [DW-1:0]      wishbone_data_o,
  output logic               wishbone_we_o,
  output logic [SEL_W-1:0]   wishbone_sel_o,
  output logic               wishbone_stb_o,
  output logic               wishbone_cyc_o
);
  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    adr_q, adr_d;
  logic [DW-1:0]    dat_q, dat_d;
  logic             we_q, we_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             cyc_q, cyc_d;
  logic [DW-1:0]    rbuf_q, rbuf_d;
  logic             err_q, err_d;
  logic             tmo_w;

`ifdef WB_TIMEOUT_EN
  wb_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q != WB_BUSY),
    .en      (state_q == WB_BUSY),
    .expired (tmo_w)
  );
`else
  assign tmo_w = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    sel_d      = sel_q;
    cyc_d      = cyc_q;
    rbuf_d     = rbuf_q;
    err_d      = err_q;
    stallreq   = 1'b0;
    cpu_data_o = '0;
    cpu_err_o  = 1'b0;
    case (state_q)
      WB_IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          state_d  = WB_BUSY;
          adr_d    = cpu_addr_i;
          dat_d    = cpu_data_i;
          we_d     = cpu_we_i;
          sel_d    = cpu_sel_i;
          cyc_d    = 1'b1;
          rbuf_d   = '0;
          err_d    = 1'b0;
          stallreq = 1'b1;
        end
      end
      WB_BUSY: begin
        // ack > err > timeout > flush
        if (wishbone_ack_i || wishbone_err_i || tmo_w) begin
          state_d = (stall_i != '0) ? WB_WAIT_FOR_STALL : WB_IDLE;
          {adr_d, dat_d, we_d, sel_d, cyc_d} = '0;
          if (wishbone_ack_i) begin
            err_d = 1'b0;
            if (we_q == WriteDisable) begin
              rbuf_d     = wishbone_data_i;
              cpu_data_o = wishbone_data_i;
            end
          end else begin
            rbuf_d    = '0;
            err_d     = 1'b1;
            cpu_err_o = 1'b1;
          end
        end else if (flush_i) begin
          state_d  = WB_IDLE;
          {adr_d, dat_d, we_d, sel_d, cyc_d} = '0;
          stallreq = 1'b1;
        end else begin
          stallreq = 1'b1;
        end
      end
      WB_WAIT_FOR_STALL: begin
        cpu_data_o = rbuf_q;
        cpu_err_o  = err_q;
        if (stall_i == '0) begin
          state_d = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
    if (rst_n == RstEnable) begin
      stallreq   = 1'b0;
      cpu_data_o = '0;
      cpu_err_o  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      state_q <= WB_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      cyc_q   <= 1'b0;
      rbuf_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
      rbuf_q  <= rbuf_d;
      err_q   <= err_d;
    end
  end

  assign wishbone_addr_o = adr_q;
  assign wishbone_data_o = dat_q;
  assign wishbone_we_o   = we_q;
  assign wishbone_sel_o  = sel_q;
  assign wishbone_stb_o  = cyc_q;
  assign wishbone_cyc_o  = cyc_q;
endmodule

// File: tb/tb_wishbone_master_if.sv
// Directed bench for wishbone_master_if: access-level expectation model
// feeding a per-cycle compare process, plus literal pins.
module tb_wishbone_master_if;
  localparam int TMO = 8;
  localparam int K_ACK = 0, K_ERR = 1, K_TMO = 2, K_FLUSH = 3, K_FLUSH_ACK = 4;

  typedef struct {
    logic        cyc;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        stallreq;
    logic [31:0] cdat;
    logic        cerr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  stall;
  logic        flush, ce, we;
  logic [31:0] addr, wdata, cdat;
  logic [3:0]  sel;
  logic        cerr, stallreq;

  int tests = 0, fails = 0, cyc_cnt = 0, ncyc = 0;
  logic [31:0] seen_cdat;
  exp_t expq[$];

  wishbone_master_if_if #(.DW(32), .AW(32)) wb ();

  wishbone_master_if #(.DW(32), .AW(32), .SEL_W(4), .STALL_W(6), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
    .cpu_ce_i(ce), .cpu_we_i(we), .cpu_addr_i(addr), .cpu_data_i(wdata), .cpu_sel_i(sel),
    .cpu_data_o(cdat), .cpu_err_o(cerr), .stallreq(stallreq),
    .wishbone_data_i(wb.dat_s2m), .wishbone_ack_i(wb.ack), .wishbone_err_i(wb.err),
    .wishbone_addr_o(wb.adr), .wishbone_data_o(wb.dat_m2s), .wishbone_we_o(wb.we),
    .wishbone_sel_o(wb.sel), .wishbone_stb_o(wb.stb), .wishbone_cyc_o(wb.cyc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", nm, ncyc, act, exp);
    end
  endtask

  function automatic exp_t zexp();
    exp_t e;
    e.cyc = 1'b0; e.we = 1'b0; e.adr = '0; e.dat = '0; e.sel = '0;
    e.stallreq = 1'b0; e.cdat = '0; e.cerr = 1'b0;
    return e;
  endfunction

  function automatic exp_t bexp(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s);
    exp_t e = zexp();
    e.cyc = 1'b1; e.we = w; e.adr = a; e.dat = d; e.sel = s; e.stallreq = 1'b1;
    return e;
  endfunction

  // One compare per cycle against the model's queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      chk("cyc", {31'b0, wb.cyc}, {31'b0, e.cyc});
      chk("stb", {31'b0, wb.stb}, {31'b0, e.cyc});
      chk("we", {31'b0, wb.we}, {31'b0, e.we});
      chk("adr", wb.adr, e.adr);
      chk("wdat", wb.dat_m2s, e.dat);
      chk("sel", {28'b0, wb.sel}, {28'b0, e.sel});
      chk("stallreq", {31'b0, stallreq}, {31'b0, e.stallreq});
      chk("cpu_data", cdat, e.cdat);
      chk("cpu_err", {31'b0, cerr}, {31'b0, e.cerr});
      if (wb.cyc === 1'b1) cyc_cnt++;
      if (cdat !== 32'h0) seen_cdat = cdat;
      ncyc++;
    end
  end

  task automatic drive(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [5:0] st, input logic fl,
                       input logic ak, input logic er, input logic [31:0] rd, input exp_t e);
    ce = c; we = w; addr = a; wdata = d; sel = s; stall = st; flush = fl;
    wb.ack = ak; wb.err = er; wb.dat_s2m = rd;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Whole access: request, BUSY waits, termination, optional stall hold, idle gap.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] rd, input int kind,
                        input int waits, input int stall_after, input int flush_at);
    exp_t e;
    int t;
    logic [5:0] st;
    logic [31:0] bufv;
    logic errv;
    e = zexp();
    e.stallreq = 1'b1;
    drive(1'b1, w, a, d, s, 6'b0, 1'b0, 1'b0, 1'b0, rd, e);
    t = (kind == K_TMO) ? TMO : (kind == K_FLUSH) ? flush_at : waits + 1;
    for (int i = 1; i < t; i++)
      drive(1'b1, w, a + 32'(i), d ^ 32'(i), ~s, 6'b0, 1'b0, 1'b0, 1'b0, rd, bexp(w, a, d, s));
    st = (stall_after > 0) ? 6'b000011 : 6'b0;
    e = bexp(w, a, d, s);
    bufv = '0;
    errv = 1'b0;
    case (kind)
      K_ACK, K_FLUSH_ACK: begin
        e.stallreq = 1'b0;
        if (!w) bufv = rd;
        e.cdat = bufv;
        drive(1'b1, w, a, d, s, st, kind == K_FLUSH_ACK, 1'b1, 1'b0, rd, e);
      end
      K_ERR, K_TMO: begin
        errv = 1'b1;
        e.stallreq = 1'b0;
        e.cerr = 1'b1;
        drive(1'b1, w, a, d, s, st, 1'b0, 1'b0, kind == K_ERR, rd, e);
      end
      default: drive(1'b0, w, a, d, s, 6'b0, 1'b1, 1'b0, 1'b0, rd, e);
    endcase
    if (kind != K_FLUSH && stall_after > 0) begin
      for (int j = 1; j <= stall_after + 1; j++) begin
        e = zexp();
        e.cdat = bufv;
        e.cerr = errv;
        drive(1'b1, ~w, ~a, d, s, (j <= stall_after) ? 6'b000011 : 6'b0, j == 1,
              1'b0, 1'b0, rd, e);
      end
    end
    if (kind == K_FLUSH)
      drive(1'b0, w, a, d, s, 6'b0, 1'b0, 1'b1, 1'b0, rd, zexp());
    drive(1'b0, 1'b0, '0, '0, '0, 6'b0, 1'b0, 1'b0, 1'b0, '0, zexp());
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
    stall = '0; flush = 1'b0; wb.ack = 1'b0; wb.err = 1'b0; wb.dat_s2m = '0;
    seen_cdat = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, combinational outputs masked even with a request present.
    drive(1'b1, 1'b0, 32'h40, 32'h1, 4'hF, 6'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, zexp());
    rst_n = 1'b1;
    // Request alongside flush is not accepted.
    drive(1'b1, 1'b0, 32'h40, 32'h1, 4'hF, 6'b0, 1'b1, 1'b0, 1'b0, '0, zexp());

    cyc_cnt = 0; seen_cdat = '0;
    access(1'b0, 32'h0000_0040, 32'h0, 4'hF, 32'hDEAD_BEEF, K_ACK, 2, 0, 0);
    chk("read_cyc_len", 32'(cyc_cnt), 32'd3);
    chk("read_data_pin", seen_cdat, 32'hDEAD_BEEF);

    cyc_cnt = 0; seen_cdat = '0;
    access(1'b1, 32'h0000_0100, 32'h0000_1234, 4'b0011, 32'h7777_7777, K_ACK, 0, 0, 0);
    chk("write_cyc_len", 32'(cyc_cnt), 32'd1);
    chk("write_no_rdata", seen_cdat, 32'h0);

    access(1'b0, 32'h0000_0200, 32'h0, 4'hF, 32'h1111_2222, K_ERR, 2, 0, 0);

`ifdef WB_TIMEOUT_EN
    cyc_cnt = 0;
    access(1'b0, 32'h0000_0300, 32'h0, 4'hF, 32'h0, K_TMO, 0, 0, 0);
    chk("timeout_cyc_len", 32'(cyc_cnt), 32'd8);
`endif

    seen_cdat = '0;
    access(1'b0, 32'h0000_0400, 32'h0, 4'hF, 32'hA5A5_A5A5, K_ACK, 1, 3, 0);
    chk("stall_hold_pin", seen_cdat, 32'hA5A5_A5A5);

    access(1'b0, 32'h0000_0500, 32'h0, 4'hF, 32'hCAFE_0001, K_ERR, 0, 2, 0);

    seen_cdat = '0;
    access(1'b0, 32'h0000_0600, 32'h0, 4'hF, 32'hCAFE_0002, K_FLUSH, 0, 0, 2);
    chk("flush_no_data", seen_cdat, 32'h0);

    access(1'b0, 32'h0000_0700, 32'h0, 4'hF, 32'h0BAD_F00D, K_FLUSH_ACK, 1, 0, 0);

    // Reset while BUSY: registered bus holds until the edge, nothing reported.
    e = zexp();
    e.stallreq = 1'b1;
    drive(1'b1, 1'b1, 32'h800, 32'h55, 4'h1, 6'b0, 1'b0, 1'b0, 1'b0, '0, e);
    drive(1'b1, 1'b1, 32'h800, 32'h55, 4'h1, 6'b0, 1'b0, 1'b0, 1'b0, '0,
          bexp(1'b1, 32'h800, 32'h55, 4'h1));
    rst_n = 1'b0;
    e = bexp(1'b1, 32'h800, 32'h55, 4'h1);
    e.stallreq = 1'b0;
    drive(1'b1, 1'b1, 32'h800, 32'h55, 4'h1, 6'b0, 1'b0, 1'b1, 1'b0, 32'h9, e);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0, 6'b0, 1'b0, 1'b0, 1'b0, '0, zexp());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
